// File: rtl/grid_mem_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto one single-port placement RAM.
// It absorbs the RAM read latency and returns the read data to the requester that owns the access.
module grid_mem_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               oor,
  output logic               busy,
  output logic               mem_read,
  output logic               mem_write,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_dataWrite,
  input  logic [DW-1:0]      mem_dataRead
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [PW:0] NREQ_W  = (PW+1)'(NREQ);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            we_q, we_d;
  logic            range_q, range_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic            oor_q, oor_d;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];
  logic            sel_found;
  logic [PW-1:0]   sel_idx;
  logic            sel_in_range;
  logic [PW:0]     cand;
  logic [PW:0]     nxt_ptr;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
  end

  // Rotating priority scan: the first active request at or after rr_ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!sel_found && req[cand[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PW-1:0];
      end
    end
    sel_in_range = ({1'b0, addr_arr[sel_idx]} < DEPTH_W);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    we_d       = we_q;
    range_d    = range_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    nxt_ptr    = {1'b0, owner_q} + (PW+1)'(1);
    if (nxt_ptr >= NREQ_W) nxt_ptr = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = ISSUE;
          owner_d = sel_idx;
          we_d    = req_we[sel_idx];
          addr_d  = addr_arr[sel_idx];
          wdata_d = wdata_arr[sel_idx];
          range_d = sel_in_range;
        end
      end
      ISSUE: begin
        rr_ptr_d = nxt_ptr[PW-1:0];
        if (we_q) begin
          state_d = IDLE;
        end else if (range_q) begin
          state_d    = WAIT;
          wait_cnt_d = CW'(RD_LAT - 1);
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) state_d = RESP;
        else                  wait_cnt_d = wait_cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulses are computed one cycle early so gnt/rvalid/oor leave straight from flops.
  always_comb begin
    gnt_d    = '0;
    rvalid_d = '0;
    oor_d    = 1'b0;
    rdata_d  = rdata_q;
    if (state_q == IDLE && sel_found) begin
      gnt_d[sel_idx] = 1'b1;
      oor_d          = !sel_in_range;
    end
    if (state_q == ISSUE && !we_q && !range_q) begin
      rvalid_d[owner_q] = 1'b1;
      rdata_d           = '1;
    end
    if (state_q == WAIT && wait_cnt_q == '0) begin
      rvalid_d[owner_q] = 1'b1;
      rdata_d           = mem_dataRead;
    end
    mem_read      = (state_q == ISSUE) && range_q && !we_q;
    mem_write     = (state_q == ISSUE) && range_q && we_q;
    mem_addr      = (state_q == ISSUE) ? addr_q : '0;
    mem_dataWrite = ((state_q == ISSUE) && range_q && we_q) ? wdata_q : '0;
    busy          = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      we_q       <= 1'b0;
      range_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      oor_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      range_q    <= range_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      oor_q      <= oor_d;
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign oor    = oor_q;
  assign rdata  = rdata_q;

  a_strobe_excl: assert property (@(posedge clk) disable iff (!reset) !(mem_read && mem_write));
  a_gnt_onehot:  assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt_q));
  a_rv_onehot:   assert property (@(posedge clk) disable iff (!reset) $onehot0(rvalid_q));

endmodule
